// File: rtl/pipe_pkg.sv
`default_nettype none
// pipe_pkg: shared pipeline-stage action encoding, counter width and payload layouts.
// Rev 1.0
package pipe_pkg;

  typedef enum logic [1:0] {
    PIPE_ADV    = 2'd0,
    PIPE_BUBBLE = 2'd1,
    PIPE_FLUSH  = 2'd2,
    PIPE_HOLD   = 2'd3
  } pipe_action_e;

  localparam int PIPE_PERF_CNT_W = 32;

  // ID/EX boundary layout; its width is the stage register's default payload width.
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_valid;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [8:0]  instr_id;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
  } id_ex_payload_t;

  localparam int ID_EX_PAYLOAD_W = $bits(id_ex_payload_t);

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// pipe_slot: one valid/payload/pc/tag pipeline register driven by the decoded stage action.
// Rev 1.0
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = 128,
  parameter int PC_W      = 32,
  parameter int TAG_W     = 6,
  parameter bit IS_HEAD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  pipe_action_e         action,
  input  logic                 up_valid,
  input  logic [PAYLOAD_W-1:0] up_payload,
  input  logic [PC_W-1:0]      up_pc,
  input  logic [TAG_W-1:0]     up_tag,
  output logic                 valid,
  output logic [PAYLOAD_W-1:0] payload,
  output logic [PC_W-1:0]      pc,
  output logic [TAG_W-1:0]     tag
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      payload <= '0;
      pc      <= '0;
      tag     <= '0;
    end else begin
      case (action)
        PIPE_HOLD: begin
          valid   <= valid;
          payload <= payload;
          pc      <= pc;
          tag     <= tag;
        end
        PIPE_FLUSH: begin
          valid   <= 1'b0;
          payload <= '0;
          pc      <= up_pc;
          tag     <= '0;
        end
        PIPE_BUBBLE: begin
          // Only the head slot takes the bubble; later slots keep draining.
          valid   <= IS_HEAD ? 1'b0 : up_valid;
          payload <= IS_HEAD ? '0   : up_payload;
          pc      <= up_pc;
          tag     <= IS_HEAD ? '0   : up_tag;
        end
        default: begin
          valid   <= up_valid;
          payload <= up_payload;
          pc      <= up_pc;
          tag     <= up_tag;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// pipe_stage_reg: DEPTH-slot pipeline stage register with freeze/bubble/flush, sequence tags,
// occupancy and optional event counters (PIPE_STAGE_PERF_CNT_EN). Rev 1.0
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = ID_EX_PAYLOAD_W,
  parameter int PC_W      = 32,
  parameter int DEPTH     = 1,
  parameter int TAG_W     = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [PAYLOAD_W-1:0]         in_payload,
  input  logic [PC_W-1:0]              in_pc,
  input  logic                         cache_stall,
  input  logic                         load_use_stall,
  input  logic                         pipeline_flush,
  output logic                         out_valid,
  output logic [PAYLOAD_W-1:0]         out_payload,
  output logic [PC_W-1:0]              out_pc,
  output logic [TAG_W-1:0]             out_tag,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [PIPE_PERF_CNT_W-1:0]   perf_freeze_cnt,
  output logic [PIPE_PERF_CNT_W-1:0]   perf_bubble_cnt,
  output logic [PIPE_PERF_CNT_W-1:0]   perf_flush_cnt
);

  localparam int OCC_W = $clog2(DEPTH+1);

  pipe_action_e         action;
  logic [DEPTH-1:0]     slot_valid;
  logic [PAYLOAD_W-1:0] slot_payload [DEPTH];
  logic [PC_W-1:0]      slot_pc      [DEPTH];
  logic [TAG_W-1:0]     slot_tag     [DEPTH];
  logic [PAYLOAD_W-1:0] head_payload;
  logic [TAG_W-1:0]     head_tag;
  logic [TAG_W-1:0]     tag_ctr;
  logic [OCC_W-1:0]     shifted_cnt;
  logic [OCC_W-1:0]     occ_nxt;

  always_comb begin
    action = PIPE_ADV;
    if (cache_stall)         action = PIPE_HOLD;
    else if (pipeline_flush) action = PIPE_FLUSH;
    else if (load_use_stall) action = PIPE_BUBBLE;
  end

  assign head_payload = in_valid ? in_payload : '0;
  assign head_tag     = in_valid ? tag_ctr    : '0;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    if (k == 0) begin : g_head
      pipe_slot #(
        .PAYLOAD_W (PAYLOAD_W), .PC_W (PC_W), .TAG_W (TAG_W), .IS_HEAD (1'b1)
      ) u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .action     (action),
        .up_valid   (in_valid),
        .up_payload (head_payload),
        .up_pc      (in_pc),
        .up_tag     (head_tag),
        .valid      (slot_valid[k]),
        .payload    (slot_payload[k]),
        .pc         (slot_pc[k]),
        .tag        (slot_tag[k])
      );
    end else begin : g_body
      pipe_slot #(
        .PAYLOAD_W (PAYLOAD_W), .PC_W (PC_W), .TAG_W (TAG_W), .IS_HEAD (1'b0)
      ) u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .action     (action),
        .up_valid   (slot_valid[k-1]),
        .up_payload (slot_payload[k-1]),
        .up_pc      (slot_pc[k-1]),
        .up_tag     (slot_tag[k-1]),
        .valid      (slot_valid[k]),
        .payload    (slot_payload[k]),
        .pc         (slot_pc[k]),
        .tag        (slot_tag[k])
      );
    end
  end

  assign out_valid   = slot_valid[DEPTH-1];
  assign out_payload = slot_payload[DEPTH-1];
  assign out_pc      = slot_pc[DEPTH-1];
  assign out_tag     = slot_tag[DEPTH-1];

  // Valid slots that survive a shift are those in 0..DEPTH-2; the last one drains out.
  always_comb begin
    shifted_cnt = '0;
    for (int k = 0; k < DEPTH-1; k++) begin
      shifted_cnt = shifted_cnt + OCC_W'(slot_valid[k]);
    end
    case (action)
      PIPE_HOLD:   occ_nxt = occupancy;
      PIPE_FLUSH:  occ_nxt = '0;
      PIPE_BUBBLE: occ_nxt = shifted_cnt;
      default:     occ_nxt = shifted_cnt + OCC_W'(in_valid);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
      tag_ctr   <= '0;
    end else begin
      occupancy <= occ_nxt;
      if (action == PIPE_ADV && in_valid) tag_ctr <= tag_ctr + TAG_W'(1);
    end
  end

`ifdef PIPE_STAGE_PERF_CNT_EN
  localparam logic [PIPE_PERF_CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_freeze_cnt <= '0;
      perf_bubble_cnt <= '0;
      perf_flush_cnt  <= '0;
    end else begin
      if (action == PIPE_HOLD && perf_freeze_cnt != CNT_MAX)
        perf_freeze_cnt <= perf_freeze_cnt + PIPE_PERF_CNT_W'(1);
      if (action == PIPE_BUBBLE && perf_bubble_cnt != CNT_MAX)
        perf_bubble_cnt <= perf_bubble_cnt + PIPE_PERF_CNT_W'(1);
      if (action == PIPE_FLUSH && perf_flush_cnt != CNT_MAX)
        perf_flush_cnt <= perf_flush_cnt + PIPE_PERF_CNT_W'(1);
    end
  end
`else
  assign perf_freeze_cnt = '0;
  assign perf_bubble_cnt = '0;
  assign perf_flush_cnt  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// tb_pipe_stage_reg: drives a DEPTH=3 and a DEPTH=1/TAG_W=2 instance with shared stimulus
// and compares both against an array-based reference pipeline. Rev 1.0
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_payload = '0;
  logic [31:0] in_pc = '0;
  logic        cache_stall = 1'b0;
  logic        load_use_stall = 1'b0;
  logic        pipeline_flush = 1'b0;

  logic        a_valid, b_valid;
  logic [31:0] a_payload, a_pc, b_payload, b_pc;
  logic [5:0]  a_tag;
  logic [1:0]  b_tag;
  logic [1:0]  a_occ;
  logic [0:0]  b_occ;
  logic [31:0] a_pf, a_pb, a_pl, b_pf, b_pb, b_pl;

  int compared = 0;
  int mismatched = 0;

  pipe_stage_reg #(.PAYLOAD_W(32), .PC_W(32), .DEPTH(3), .TAG_W(6)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_payload(in_payload), .in_pc(in_pc),
    .cache_stall(cache_stall), .load_use_stall(load_use_stall), .pipeline_flush(pipeline_flush),
    .out_valid(a_valid), .out_payload(a_payload), .out_pc(a_pc), .out_tag(a_tag),
    .occupancy(a_occ), .perf_freeze_cnt(a_pf), .perf_bubble_cnt(a_pb), .perf_flush_cnt(a_pl)
  );

  pipe_stage_reg #(.PAYLOAD_W(32), .PC_W(32), .DEPTH(1), .TAG_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_payload(in_payload), .in_pc(in_pc),
    .cache_stall(cache_stall), .load_use_stall(load_use_stall), .pipeline_flush(pipeline_flush),
    .out_valid(b_valid), .out_payload(b_payload), .out_pc(b_pc), .out_tag(b_tag),
    .occupancy(b_occ), .perf_freeze_cnt(b_pf), .perf_bubble_cnt(b_pb), .perf_flush_cnt(b_pl)
  );

  always #5 clk = ~clk;

  logic [72:0] obs [2];
  assign obs[0] = {a_valid, a_payload, a_pc, a_tag, a_occ};
  assign obs[1] = {b_valid, b_payload, b_pc, 4'b0, b_tag, 1'b0, b_occ};

  // Reference model: each pipeline is an array of instruction records.
  bit          mv  [2][3];
  logic [31:0] mp  [2][3];
  logic [31:0] mpc [2][3];
  logic [5:0]  mt  [2][3];
  int unsigned mtag [2];
  int          dep  [2] = '{3, 1};
  int unsigned tmod [2] = '{64, 4};
  int unsigned n_hold, n_bub, n_flush;

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 3; k++) begin
        mv[m][k] = 1'b0; mp[m][k] = '0; mpc[m][k] = '0; mt[m][k] = '0;
      end
      mtag[m] = 0;
    end
    n_hold = 0; n_bub = 0; n_flush = 0;
  endfunction

  function automatic void model_step();
    if (cache_stall) begin
      n_hold++;
      return;
    end
    if (pipeline_flush) n_flush++;
    else if (load_use_stall) n_bub++;
    for (int m = 0; m < 2; m++) begin
      for (int k = dep[m]-1; k >= 1; k--) begin
        mv[m][k] = mv[m][k-1]; mp[m][k] = mp[m][k-1];
        mpc[m][k] = mpc[m][k-1]; mt[m][k] = mt[m][k-1];
      end
      mpc[m][0] = in_pc;
      if (pipeline_flush) begin
        for (int k = 0; k < dep[m]; k++) begin
          mv[m][k] = 1'b0; mp[m][k] = '0; mt[m][k] = '0;
        end
      end else if (load_use_stall || !in_valid) begin
        mv[m][0] = 1'b0; mp[m][0] = '0; mt[m][0] = '0;
      end else begin
        mv[m][0] = 1'b1; mp[m][0] = in_payload; mt[m][0] = 6'(mtag[m]);
        mtag[m] = (mtag[m] + 1) % tmod[m];
      end
    end
  endfunction

  function automatic logic [72:0] exp_vec(int m);
    int c = 0;
    int l = dep[m] - 1;
    for (int k = 0; k < dep[m]; k++) c += int'(mv[m][k]);
    return {mv[m][l], mp[m][l], mpc[m][l], mt[m][l], 2'(c)};
  endfunction

  function automatic logic [31:0] exp_perf(int unsigned n);
`ifdef PIPE_STAGE_PERF_CNT_EN
    return n;
`else
    return (n == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_ctrl(input logic v, input logic st, input logic fl, input logic bu);
    in_valid = v; cache_stall = st; pipeline_flush = fl; load_use_stall = bu;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    for (int m = 0; m < 2; m++) begin
      compared++;
      if (obs[m] !== 73'd0) begin
        mismatched++;
        $display("FAIL reset dut%0d: got %h want 0", m, obs[m]);
      end
    end
    compared++;
    if ({a_pf, a_pb, a_pl, b_pf, b_pb, b_pl} !== '0) begin
      mismatched++;
      $display("FAIL reset_perf: got %h %h %h want 0", a_pf, a_pb, a_pl);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 6; i++) begin
      set_ctrl(i < 3, 1'b0, 1'b0, 1'b0);
      in_payload = 32'(i + 1);
      in_pc = 32'h100 + 32'(4 * i);
      tick();
      for (int m = 0; m < 2; m++) begin
        compared++;
        if (obs[m] !== exp_vec(m)) begin
          mismatched++;
          $display("FAIL stream dut%0d cyc%0d: got %h want %h", m, i, obs[m], exp_vec(m));
        end
      end
      if (i >= 2 && i <= 4) begin
        compared++;
        if ({a_valid, a_payload, a_pc, a_tag} !== {1'b1, 32'(i - 1), 32'h100 + 32'(4 * (i - 2)), 6'(i - 2)}) begin
          mismatched++;
          $display("FAIL stream_out cyc%0d: got %h/%h/%h/%h", i, a_valid, a_payload, a_pc, a_tag);
        end
      end
    end
  endtask

  task automatic test_bubble();
    set_ctrl(1'b1, 1'b0, 1'b0, 1'b1);
    in_payload = $urandom;
    in_pc = 32'h200;
    tick();
    compared++;
    if ({b_valid, b_payload, b_pc} !== {1'b0, 32'd0, 32'h200}) begin
      mismatched++;
      $display("FAIL bubble: got %h/%h/%h want 0/0/200", b_valid, b_payload, b_pc);
    end
    set_ctrl(1'b1, 1'b0, 1'b0, 1'b0);
    in_payload = $urandom;
    in_pc = 32'h204;
    tick();
    for (int m = 0; m < 2; m++) begin
      compared++;
      if (obs[m] !== exp_vec(m)) begin
        mismatched++;
        $display("FAIL bubble_next dut%0d: got %h want %h", m, obs[m], exp_vec(m));
      end
    end
  endtask

  task automatic test_hold_flush();
    for (int i = 0; i < 3; i++) begin
      set_ctrl(1'b1, 1'b0, 1'b0, 1'b0);
      in_payload = $urandom;
      in_pc = $urandom;
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      set_ctrl(1'b1, 1'b1, 1'b1, 1'b0);
      in_pc = $urandom;
      tick();
      compared++;
      if (a_occ !== 2'd3 || obs[0] !== exp_vec(0)) begin
        mismatched++;
        $display("FAIL hold_flush occ=%0d got %h want %h", a_occ, obs[0], exp_vec(0));
      end
    end
    set_ctrl(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    for (int m = 0; m < 2; m++) begin
      compared++;
      if (obs[m] !== exp_vec(m) || {a_valid, a_occ} !== 3'd0) begin
        mismatched++;
        $display("FAIL flush_release dut%0d: got %h want %h", m, obs[m], exp_vec(m));
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      set_ctrl(1'b1, 1'b0, 1'b0, 1'b0);
      in_payload = $urandom;
      in_pc = $urandom;
      tick();
    end
    compared++;
    if (a_occ !== 2'd2) begin
      mismatched++;
      $display("FAIL async_pre occ: got %0d want 2", a_occ);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int m = 0; m < 2; m++) begin
      compared++;
      if (obs[m] !== 73'd0) begin
        mismatched++;
        $display("FAIL async_reset dut%0d: got %h want 0", m, obs[m]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_tag_wrap();
    for (int i = 0; i < 5; i++) begin
      set_ctrl(1'b1, 1'b0, 1'b0, 1'b0);
      in_payload = $urandom;
      in_pc = $urandom;
      tick();
      compared++;
      if (b_tag !== 2'(i % 4) || obs[1] !== exp_vec(1)) begin
        mismatched++;
        $display("FAIL tag_wrap i%0d: got tag %0d want %0d", i, b_tag, i % 4);
      end
    end
  endtask

  task automatic test_perf();
    pulse_reset();
    set_ctrl(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) tick();
    set_ctrl(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (2) tick();
    set_ctrl(1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
    compared++;
    if ({a_pf, a_pb, a_pl} !== {exp_perf(4), exp_perf(2), exp_perf(1)}) begin
      mismatched++;
      $display("FAIL perf_a: got %0d/%0d/%0d", a_pf, a_pb, a_pl);
    end
    compared++;
    if ({b_pf, b_pb, b_pl} !== {exp_perf(n_hold), exp_perf(n_bub), exp_perf(n_flush)}) begin
      mismatched++;
      $display("FAIL perf_b: got %0d/%0d/%0d", b_pf, b_pb, b_pl);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_ctrl(($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 16) == 0, ($urandom % 8) == 0);
      in_payload = $urandom;
      in_pc = $urandom;
      tick();
      for (int m = 0; m < 2; m++) begin
        compared++;
        if (obs[m] !== exp_vec(m)) begin
          mismatched++;
          $display("FAIL random dut%0d cyc%0d: got %h want %h", m, i, obs[m], exp_vec(m));
        end
      end
    end
    compared++;
    if ({a_pf, a_pb, a_pl} !== {exp_perf(n_hold), exp_perf(n_bub), exp_perf(n_flush)}) begin
      mismatched++;
      $display("FAIL random_perf: got %0d/%0d/%0d want %0d/%0d/%0d", a_pf, a_pb, a_pl,
               exp_perf(n_hold), exp_perf(n_bub), exp_perf(n_flush));
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_bubble();
    test_hold_flush();
    test_async_reset();
    test_tag_wrap();
    test_perf();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
